// File: rtl/upsampling_engine.sv
// Nearest-neighbour image upsampler: reads each source pixel, writes it SCALE times per output row, repeats each row SCALE times.
// Optional abort input/aborted output are enabled with `define UPS_ABORT_EN.
module upsampling_engine #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 16,
    parameter int DIM_W   = 8,
    parameter int SCALE   = 2,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DIM_W-1:0]  src_w,
    input  logic [DIM_W-1:0]  src_h,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef UPS_ABORT_EN
    ,
    input  logic              abort,
    output logic              aborted
`endif
);

    localparam int SC_W  = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [DIM_W-1:0]  w_q, w_d, h_q, h_d;
    logic [DIM_W-1:0]  x_q, x_d, y_q, y_d;
    logic [SC_W-1:0]   rx_q, rx_d, ry_q, ry_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [ADDR_W-1:0] row_ptr_q, row_ptr_d;
    logic [ADDR_W-1:0] dst_base_q, dst_base_d;
    logic [ADDR_W-1:0] out_cnt_q, out_cnt_d;
    logic [DATA_W-1:0] pix_q, pix_d;
    logic              err_q, err_d;
    logic              aborted_q, aborted_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            w_q        <= '0;
            h_q        <= '0;
            x_q        <= '0;
            y_q        <= '0;
            rx_q       <= '0;
            ry_q       <= '0;
            lat_q      <= '0;
            row_ptr_q  <= '0;
            dst_base_q <= '0;
            out_cnt_q  <= '0;
            pix_q      <= '0;
            err_q      <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            w_q        <= w_d;
            h_q        <= h_d;
            x_q        <= x_d;
            y_q        <= y_d;
            rx_q       <= rx_d;
            ry_q       <= ry_d;
            lat_q      <= lat_d;
            row_ptr_q  <= row_ptr_d;
            dst_base_q <= dst_base_d;
            out_cnt_q  <= out_cnt_d;
            pix_q      <= pix_d;
            err_q      <= err_d;
            aborted_q  <= aborted_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        w_d        = w_q;
        h_d        = h_q;
        x_d        = x_q;
        y_d        = y_q;
        rx_d       = rx_q;
        ry_d       = ry_q;
        lat_d      = lat_q;
        row_ptr_d  = row_ptr_q;
        dst_base_d = dst_base_q;
        out_cnt_d  = out_cnt_q;
        pix_d      = pix_q;
        err_d      = 1'b0;
        aborted_d  = aborted_q;
        rd_en      = 1'b0;
        rd_addr    = '0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        busy       = 1'b0;
        done       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (src_w == '0 || src_h == '0) begin
                        err_d = 1'b1;
                    end else begin
                        w_d        = src_w;
                        h_d        = src_h;
                        x_d        = '0;
                        y_d        = '0;
                        ry_d       = '0;
                        row_ptr_d  = src_base;
                        dst_base_d = dst_base;
                        out_cnt_d  = '0;
                        aborted_d  = 1'b0;
                        state_d    = S_READ;
                    end
                end
            end
            S_READ: begin
                busy    = 1'b1;
                rd_en   = 1'b1;
                rd_addr = row_ptr_q + ADDR_W'(x_q);
                lat_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (lat_q == LAT_W'(MEM_LAT - 1)) begin
                    pix_d   = rd_data;
                    rx_d    = '0;
                    state_d = S_WRITE;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            S_WRITE: begin
                busy      = 1'b1;
                wr_en     = 1'b1;
                wr_addr   = dst_base_q + out_cnt_q;
                wr_data   = pix_q;
                out_cnt_d = out_cnt_q + ADDR_W'(1);
                // Row replicas re-read the same source row, so row_ptr only moves when y moves
                if (rx_q == SC_W'(SCALE - 1)) begin
                    state_d = S_READ;
                    if (x_q == w_q - DIM_W'(1)) begin
                        x_d = '0;
                        if (ry_q == SC_W'(SCALE - 1)) begin
                            ry_d      = '0;
                            y_d       = y_q + DIM_W'(1);
                            row_ptr_d = row_ptr_q + ADDR_W'(w_q);
                            if (y_q == h_q - DIM_W'(1)) begin
                                state_d = S_DONE;
                            end
                        end else begin
                            ry_d = ry_q + SC_W'(1);
                        end
                    end else begin
                        x_d = x_q + DIM_W'(1);
                    end
                end else begin
                    rx_d = rx_q + SC_W'(1);
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

`ifdef UPS_ABORT_EN
        if (abort && busy) begin
            state_d   = S_DONE;
            aborted_d = 1'b1;
        end
`endif
    end

    assign err = err_q;

`ifdef UPS_ABORT_EN
    assign aborted = (state_q == S_DONE) && aborted_q;
`endif

endmodule

// File: tb/tb_upsampling_engine.sv
// Scoreboard bench for upsampling_engine: expected read/write streams come from a raster-order reference model.
// Abort scenarios are included when UPS_ABORT_EN is defined.
module tb_upsampling_engine;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 16;
    localparam int DIM_W   = 8;
    localparam int SCALE   = 2;
    localparam int MEM_LAT = 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [DIM_W-1:0]  src_w = '0;
    logic [DIM_W-1:0]  src_h = '0;
    logic [ADDR_W-1:0] src_base = '0;
    logic [ADDR_W-1:0] dst_base = '0;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data = '0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;
    logic              err;
    logic              abort = 1'b0;
    logic              aborted_w;

    upsampling_engine #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W), .SCALE(SCALE), .MEM_LAT(MEM_LAT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .src_w(src_w), .src_h(src_h),
        .src_base(src_base), .dst_base(dst_base), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err)
`ifdef UPS_ABORT_EN
        , .abort(abort), .aborted(aborted_w)
`endif
    );

`ifndef UPS_ABORT_EN
    assign aborted_w = 1'b0;
`endif

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] exp_rd_q [$];
    logic [ADDR_W-1:0] exp_wa_q [$];
    logic [DATA_W-1:0] exp_wd_q [$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int start_cyc = 0;
    int busy_cnt = 0, rd_cnt = 0, wr_cnt = 0, done_cnt = 0, done_cyc = 0, err_cnt = 0;
    int aborted_seen = 0;

    // Source memory: data appears one cycle after a read; garbage otherwise so mistimed sampling is visible
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
        else       rd_data <= DATA_W'($urandom);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT touches memory
    always @(negedge clk) begin
        cyc++;
        if (busy) busy_cnt++;
        if (err) err_cnt++;
        if (rd_en || wr_en) checkOutput("rd_wr_exclusive", 32'(rd_en && wr_en), 0);
        if (rd_en) begin
            rd_cnt++;
            if (exp_rd_q.size() == 0) checkOutput("rd_unexpected", 1, 0);
            else checkOutput("rd_addr", 32'(rd_addr), 32'(exp_rd_q.pop_front()));
        end
        if (wr_en) begin
            wr_cnt++;
            if (exp_wa_q.size() == 0) checkOutput("wr_unexpected", 1, 0);
            else begin
                checkOutput("wr_addr", 32'(wr_addr), 32'(exp_wa_q.pop_front()));
                checkOutput("wr_data", 32'(wr_data), 32'(exp_wd_q.pop_front()));
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            aborted_seen = int'(aborted_w);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic loadRandom(input logic [ADDR_W-1:0] src, input int n);
        logic [ADDR_W-1:0] a;
        for (int i = 0; i < n; i++) begin
            a = src + ADDR_W'(i);
            mem[a] = DATA_W'($urandom);
        end
    endtask

    // Reference model: every output pixel in raster order maps back to source (oy/SCALE, ox/SCALE)
    task automatic pushModel(input int w, input int h, input logic [ADDR_W-1:0] src,
                             input logic [ADDR_W-1:0] dst);
        logic [ADDR_W-1:0] a;
        for (int oy = 0; oy < h * SCALE; oy++)
            for (int ox = 0; ox < w * SCALE; ox++) begin
                a = dst + ADDR_W'(oy * w * SCALE + ox);
                exp_wa_q.push_back(a);
                a = src + ADDR_W'((oy / SCALE) * w + ox / SCALE);
                exp_wd_q.push_back(mem[a]);
            end
        for (int oy = 0; oy < h * SCALE; oy++)
            for (int x = 0; x < w; x++)
                exp_rd_q.push_back(src + ADDR_W'((oy / SCALE) * w + x));
    endtask

    task automatic flushModel();
        exp_rd_q.delete();
        exp_wa_q.delete();
        exp_wd_q.delete();
    endtask

    task automatic issueStart(input int w, input int h, input logic [ADDR_W-1:0] src,
                              input logic [ADDR_W-1:0] dst);
        tick();
        start = 1'b1;
        src_w = DIM_W'(w);
        src_h = DIM_W'(h);
        src_base = src;
        dst_base = dst;
        start_cyc = cyc;
        busy_cnt = 0; rd_cnt = 0; wr_cnt = 0; done_cnt = 0; err_cnt = 0;
        tick();
        start = 1'b0;
    endtask

    // One full run; inject_at >= 0 pulses a conflicting start on that busy cycle
    task automatic applyStimulus(input int w, input int h, input logic [ADDR_W-1:0] src,
                                 input logic [ADDR_W-1:0] dst, input int inject_at);
        int exp_busy;
        exp_busy = w * h * SCALE * (1 + MEM_LAT + SCALE);
        pushModel(w, h, src, dst);
        issueStart(w, h, src, dst);
        for (int i = 0; i < exp_busy + 20 && done_cnt == 0; i++) begin
            if (cyc - start_cyc == inject_at) begin
                start = 1'b1;
                src_w = 8'd3;
                src_h = 8'd1;
                src_base = 16'h4000;
                dst_base = 16'h5000;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        checkOutput("done_seen", done_cnt, 1);
        checkOutput("busy_cycles", busy_cnt, exp_busy);
        checkOutput("done_latency", done_cyc - start_cyc, exp_busy + 1);
        checkOutput("read_count", rd_cnt, w * h * SCALE);
        checkOutput("write_count", wr_cnt, w * h * SCALE * SCALE);
        checkOutput("writes_left", exp_wa_q.size(), 0);
        checkOutput("aborted_normal", aborted_seen, 0);
        flushModel();
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_rd_en"}, 32'(rd_en), 0);
        checkOutput({tag, "_wr_en"}, 32'(wr_en), 0);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
        checkOutput({tag, "_done"}, 32'(done), 0);
        checkOutput({tag, "_err"}, 32'(err), 0);
        checkOutput({tag, "_rd_addr"}, 32'(rd_addr), 0);
        checkOutput({tag, "_wr_addr"}, 32'(wr_addr), 0);
        checkOutput({tag, "_wr_data"}, 32'(wr_data), 0);
    endtask

    task automatic loadTestImage();
        mem[16'h0000] = 8'd11;
        mem[16'h0001] = 8'd22;
        mem[16'h0002] = 8'd33;
        mem[16'h0003] = 8'd44;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w, h;
        logic [ADDR_W-1:0] s, d;

        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        tick();
        tick();
        checkIdleOutputs("reset");
        reset = 1'b1;

        // Fixed 2x2 image, then an immediate rerun one cycle after done with a stray start mid-run
        loadTestImage();
        applyStimulus(2, 2, 16'h0000, 16'h0100, -1);
        applyStimulus(2, 2, 16'h0000, 16'h0100, 10);

        // Zero-dimension start is rejected without touching memory
        issueStart(0, 4, 16'h0000, 16'h0200);
        checkOutput("err_pulse", 32'(err), 1);
        checkOutput("err_busy", 32'(busy), 0);
        tick(); tick(); tick();
        checkOutput("err_once", err_cnt, 1);
        checkOutput("err_no_activity", rd_cnt + wr_cnt + busy_cnt, 0);
        applyStimulus(1, 1, 16'h0002, 16'h0300, -1);

        // Asynchronous reset after the fifth write, then a clean restart
        pushModel(2, 2, 16'h0000, 16'h0100);
        issueStart(2, 2, 16'h0000, 16'h0100);
        for (int i = 0; i < 100 && wr_cnt < 5; i++) tick();
        checkOutput("reset_reach_5", wr_cnt, 5);
        @(posedge clk);
        #2;
        reset = 1'b0;
        flushModel();
        #1;
        checkIdleOutputs("midrst");
        tick(); tick(); tick();
        checkOutput("midrst_no_writes", wr_cnt, 5);
        reset = 1'b1;
        applyStimulus(2, 2, 16'h0000, 16'h0100, -1);

        // Destination address wrap
        loadRandom(16'h1000, 2);
        applyStimulus(1, 2, 16'h1000, 16'hFFFE, -1);

        // Randomised images, including a source that wraps the address space
        for (int k = 0; k < 6; k++) begin
            w = int'($urandom_range(1, 4));
            h = int'($urandom_range(1, 4));
            s = (k == 5) ? 16'hFFFC : ADDR_W'($urandom);
            d = ADDR_W'($urandom);
            loadRandom(s, w * h);
            applyStimulus(w, h, s, d, (k == 2) ? 7 : -1);
        end

`ifdef UPS_ABORT_EN
        // Abort on busy cycle 6: no further memory traffic, done and aborted together
        loadTestImage();
        pushModel(2, 2, 16'h0000, 16'h0100);
        issueStart(2, 2, 16'h0000, 16'h0100);
        for (int i = 0; i < 20 && cyc - start_cyc < 6; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        flushModel();
        checkOutput("abort_done", done_cnt, 1);
        checkOutput("abort_aborted", aborted_seen, 1);
        checkOutput("abort_done_cycle", done_cyc - start_cyc, 7);
        tick(); tick(); tick(); tick();
        checkOutput("abort_quiet", 32'(busy), 0);
        checkOutput("abort_single_done", done_cnt, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort_idle_ignored", done_cnt, 1);
        applyStimulus(2, 2, 16'h0000, 16'h0100, -1);
`endif

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
